nios_simple_sysid_checker: RTL and testbench
============================================

// Module: nios_simple_sysid_checker
// PURPOSE
//  Avalon-MM read master that queries the system-ID responder after reset or on request.
//  Reads word 0 (system ID), then word 1 (generation timestamp), and compares each against expected values.
//  Reports done/pass/fail so boot logic can hold the Nios core if the FPGA image and software build mismatch.
//  Sits beside the CPU on the same interconnect, as a second master on the sysid control slave.
// PARAMETERS
//  EXPECTED_ID     32'h0000_0000  value required at word 0
//  EXPECTED_TS     32'h6606_C6D8  value required at word 1 (1711720152)
//  TIMEOUT_CYCLES  256            cycles allowed per read, issue to readdatavalid (only with timeout macro)
//  MAX_RETRIES     2              re-issues of a timed-out read before failing (0..15)
// PORTS
//  clock              in   1   system clock
//  reset_n            in   1   asynchronous active-low reset
//  start              in   1   1-cycle pulse; begins a check (honoured only in IDLE/DONE)
//  avm_address        out  1   word address: 0 = ID, 1 = timestamp
//  avm_read           out  1   read request
//  avm_waitrequest    in   1   interconnect stall
//  avm_readdatavalid  in   1   read data qualifier
//  avm_readdata       in   32  read data
//  busy               out  1   check in progress
//  done               out  1   sticky: check finished (pass or fail)
//  pass               out  1   sticky: both words matched
//  id_mismatch        out  1   sticky: word 0 != EXPECTED_ID
//  ts_mismatch        out  1   sticky: word 1 != EXPECTED_TS
//  timeout            out  1   sticky: retries exhausted (tied 0 without macro)
//  read_id            out  32  captured word 0
//  read_ts            out  32  captured word 1
// BEHAVIOUR
//  One clock domain; reset is asynchronous and active-low. Reset values: all outputs 0, FSM IDLE, counters 0.
//  Reset mid-transaction: avm_read drops immediately (async); any late readdatavalid after reset is ignored.
//  FSM: IDLE -start-> ISSUE_ID -accept-> WAIT_ID -rdv-> ISSUE_TS -accept-> WAIT_TS -rdv-> DONE -start-> ISSUE_ID.
//  - accept = avm_read & !avm_waitrequest.
//  - avm_read, avm_address held stable through ISSUE_x until accept. avm_read is low in all other states.
//  - Only one read is outstanding at a time. readdatavalid is sampled only in WAIT_x; ignored elsewhere.
//  - In WAIT_ID, rdv latches read_id and sets id_mismatch if unequal. A mismatch does not abort; the TS is still read.
//  - Entering DONE: done=1, pass=!(id_mismatch|ts_mismatch|timeout), busy=0.
//  - start while busy is ignored. start in DONE clears done/pass/flags/captures (not the captured words' history) and restarts.
//  - Best case, zero-wait slave with readdatavalid 1 cycle after accept: start to done = 5 cycles.
//  - busy is 1 in all ISSUE_x/WAIT_x states.
// CONFIGURATION
//  SYSID_CHECKER_TIMEOUT_EN defined:
//  - A per-read counter starts at accept and counts up while in WAIT_x (also while stalled in ISSUE_x).
//  - At TIMEOUT_CYCLES-1 without rdv, the same read is re-issued and the retry count increments.
//  - After MAX_RETRIES re-issues, timeout=1, the remaining read is skipped, and the FSM goes to DONE with pass=0.
//  - rdv in the same cycle as expiry: data wins, no retry.
//  SYSID_CHECKER_TIMEOUT_EN undefined: no counter logic; a hung slave leaves busy=1 forever; timeout tied 0.
// STRUCTURE
//  Package nios_simple_sysid_pkg holds:
//  - state enum;
//  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
//  - the default expected constants.
//  Sub-module nios_simple_sysid_rd_xact: single-read engine (issue/accept/wait/timeout/retry).
//  - Inputs: go, addr. Outputs: rdata_valid, rdata, timed_out.
//  - Instantiated once; the top FSM sequences the two words and performs the compares.
// TESTING
//  1 Zero-wait model returning 0 / 1711720152 -> done=1, pass=1 at 5th cycle after start; read_ts=32'h6606_C6D8.
//  2 Model returns 0x1 at word 0 -> id_mismatch=1, TS still read, pass=0, ts_mismatch=0.
//  3 waitrequest high 7 cycles on word 1 -> avm_read/avm_address stable all 7 cycles; one read per word; pass=1.
//  4 Macro on, TIMEOUT_CYCLES=16, MAX_RETRIES=2, slave never asserts rdv -> 3 issues of address 0,
//    then timeout=1, done=1, pass=0, word 1 never issued.
//  5 reset_n low during WAIT_TS, then stray rdv after release -> all outputs 0, FSM IDLE, rdv ignored.
//  6 start pulse while busy -> no effect; start in DONE -> flags clear and a second full check runs.

Source files
------------

// File: rtl/nios_simple_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package nios_simple_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_ID,
        ST_WAIT_ID,
        ST_ISSUE_TS,
        ST_WAIT_TS,
        ST_DONE
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEF_EXPECTED_ID    = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEF_EXPECTED_TS    = 32'h6606_C6D8;
    localparam int unsigned SYSID_DEF_TIMEOUT_CYCLES = 256;
    localparam int unsigned SYSID_DEF_MAX_RETRIES    = 2;

endpackage

// File: rtl/nios_simple_sysid_rd_xact.sv
// Single Avalon-MM read engine: drives the request while go_i is high,
// tracks the one outstanding read and, when SYSID_CHECKER_TIMEOUT_EN is
// defined, times it out and asks for re-issues.
module nios_simple_sysid_rd_xact
    import nios_simple_sysid_pkg::*;
`ifdef SYSID_CHECKER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = SYSID_DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES    = SYSID_DEF_MAX_RETRIES
)
`endif
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        go_i,
    input  logic        addr_i,
    output logic        avm_read_o,
    output logic        avm_address_o,
    input  logic        avm_waitrequest_i,
    input  logic        avm_readdatavalid_i,
    input  logic [31:0] avm_readdata_i,
    output logic        accept_o,
    output logic        rdata_valid_o,
    output logic [31:0] rdata_o,
    output logic        retry_o,
    output logic        timed_out_o
);

    logic pend_q, pend_d;
    logic accept, rdv, expire;

    // Request is held by the caller; address and read just follow go_i.
    assign avm_read_o    = go_i;
    assign avm_address_o = addr_i;
    assign accept        = go_i & ~avm_waitrequest_i;
    // Data is only believed while a read is actually outstanding.
    assign rdv           = pend_q & avm_readdatavalid_i;
    assign accept_o      = accept;
    assign rdata_valid_o = rdv;
    assign rdata_o       = avm_readdata_i;

`ifdef SYSID_CHECKER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    rty_q, rty_d;

    // Per-read age counter and retry bookkeeping; data arriving on the
    // expiry cycle wins over the retry.
    always_comb begin
        expire = (go_i | pend_q) & ~accept & ~rdv & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        cnt_d  = cnt_q;
        rty_d  = rty_q;
        if (accept | rdv | expire) cnt_d = '0;
        else if (go_i | pend_q)    cnt_d = cnt_q + 1'b1;
        if (rdv | timed_out_o)     rty_d = '0;
        else if (retry_o)          rty_d = rty_q + 1'b1;
    end

    assign retry_o     = expire & (rty_q != 4'(MAX_RETRIES));
    assign timed_out_o = expire & (rty_q == 4'(MAX_RETRIES));

    // Counter state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            rty_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rty_q <= rty_d;
        end
    end
`else
    assign expire      = 1'b0;
    assign retry_o     = 1'b0;
    assign timed_out_o = 1'b0;
`endif

    // Outstanding flag: set on accept, cleared by data or an expiry.
    always_comb begin
        pend_d = pend_q;
        if (accept)            pend_d = 1'b1;
        else if (rdv | expire) pend_d = 1'b0;
    end

    // Outstanding flag register; reset drops any in-flight read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pend_q <= 1'b0;
        else          pend_q <= pend_d;
    end

endmodule

// File: rtl/nios_simple_sysid_checker.sv
// Boot-time system-ID checker: reads sysid word 0 and word 1 through
// the read engine and compares them against the expected build values.
// Optional read timeout/retry: define SYSID_CHECKER_TIMEOUT_EN.
module nios_simple_sysid_checker
    import nios_simple_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEF_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = SYSID_DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES    = SYSID_DEF_MAX_RETRIES
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_ts
);

    if (MAX_RETRIES > 15 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
        $error("nios_simple_sysid_checker: MAX_RETRIES must be 0..15 and TIMEOUT_CYCLES >= 2");
    end

    state_e      state_q, state_d;
    logic        go, addr, accept, rdv, retry, timed_out, start_ok, ts_neq;
    logic [31:0] rdata;
    logic        done_q, pass_q, id_mm_q, ts_mm_q, to_q;
    logic [31:0] read_id_q, read_ts_q;

    nios_simple_sysid_rd_xact
`ifdef SYSID_CHECKER_TIMEOUT_EN
        #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRIES(MAX_RETRIES))
`endif
    u_rd (
        .clock              (clock),
        .reset_n            (reset_n),
        .go_i               (go),
        .addr_i             (addr),
        .avm_read_o         (avm_read),
        .avm_address_o      (avm_address),
        .avm_waitrequest_i  (avm_waitrequest),
        .avm_readdatavalid_i(avm_readdatavalid),
        .avm_readdata_i     (avm_readdata),
        .accept_o           (accept),
        .rdata_valid_o      (rdv),
        .rdata_o            (rdata),
        .retry_o            (retry),
        .timed_out_o        (timed_out)
    );

    assign start_ok = start & (state_q == ST_IDLE || state_q == ST_DONE);
    assign ts_neq   = (rdata != EXPECTED_TS);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Sequencing of the two word reads; a timeout skips whatever is left.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_ISSUE_ID;
            ST_ISSUE_ID: begin
                if (timed_out)   state_d = ST_DONE;
                else if (accept) state_d = ST_WAIT_ID;
            end
            ST_WAIT_ID: begin
                if (rdv)            state_d = ST_ISSUE_TS;
                else if (timed_out) state_d = ST_DONE;
                else if (retry)     state_d = ST_ISSUE_ID;
            end
            ST_ISSUE_TS: begin
                if (timed_out)   state_d = ST_DONE;
                else if (accept) state_d = ST_WAIT_TS;
            end
            ST_WAIT_TS: begin
                if (rdv)            state_d = ST_DONE;
                else if (timed_out) state_d = ST_DONE;
                else if (retry)     state_d = ST_ISSUE_TS;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: request strobe, word address and busy.
    always_comb begin
        busy = 1'b0;
        go   = 1'b0;
        addr = SYSID_ADDR_ID;
        unique case (state_q)
            ST_ISSUE_ID: begin busy = 1'b1; go = 1'b1; end
            ST_WAIT_ID:  busy = 1'b1;
            ST_ISSUE_TS: begin busy = 1'b1; go = 1'b1; addr = SYSID_ADDR_TS; end
            ST_WAIT_TS:  busy = 1'b1;
            default: ;
        endcase
    end

    // Sticky result flags and captured words; a honoured start wipes them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            id_mm_q   <= 1'b0;
            ts_mm_q   <= 1'b0;
            to_q      <= 1'b0;
            read_id_q <= '0;
            read_ts_q <= '0;
        end else if (start_ok) begin
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            id_mm_q   <= 1'b0;
            ts_mm_q   <= 1'b0;
            to_q      <= 1'b0;
            read_id_q <= '0;
            read_ts_q <= '0;
        end else if (state_q == ST_WAIT_ID && rdv) begin
            read_id_q <= rdata;
            id_mm_q   <= (rdata != EXPECTED_ID);
        end else if (state_q == ST_WAIT_TS && rdv) begin
            read_ts_q <= rdata;
            ts_mm_q   <= ts_neq;
            done_q    <= 1'b1;
            pass_q    <= ~(id_mm_q | ts_neq | to_q);
        end else if (timed_out) begin
            to_q      <= 1'b1;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = id_mm_q;
    assign ts_mismatch = ts_mm_q;
    assign timeout     = to_q;
    assign read_id     = read_id_q;
    assign read_ts     = read_ts_q;

endmodule

// File: tb/tb_nios_simple_sysid_checker.sv
// Bench for nios_simple_sysid_checker: behavioural Avalon slave plus a
// result model derived from the expected words and slave timing.
module tb_nios_simple_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h6606_C6D8;

    logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic        avm_read, avm_address;
    logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] read_id, read_ts;

    always #5 clock = ~clock;

    nios_simple_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid), .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .pass(pass), .id_mismatch(id_mismatch),
        .ts_mismatch(ts_mismatch), .timeout(timeout), .read_id(read_id), .read_ts(read_ts)
    );

    int total = 0, bad = 0;

    // slave configuration (written only by the stimulus process)
    logic [31:0] sl_word [2];
    int          sl_stall[2];
    int          sl_lat  [2];
    bit          sl_nordv = 1'b0, stray_req = 1'b0;

    // slave state and logs (written only by the slave process)
    bit          in_req = 1'b0, prev_stalled = 1'b0;
    logic        prev_addr = 1'b0;
    int          stall_rem = 0, rdv_cd = 0, stall_seen = 0, stable_err = 0;
    logic [31:0] rdv_data = '0;
    int          iss_addr[$];

    // Behavioural slave, evaluated mid-cycle so all DUT outputs are settled.
    always @(negedge clock) begin
        if (!reset_n) begin
            in_req = 0; stall_rem = 0; rdv_cd = 0; prev_stalled = 0;
            avm_waitrequest = 0; avm_readdatavalid = 0;
        end else begin
            avm_readdatavalid = 0;
            if (rdv_cd > 0) begin
                rdv_cd--;
                if (rdv_cd == 0) begin avm_readdatavalid = 1; avm_readdata = rdv_data; end
            end
            if (stray_req) begin avm_readdatavalid = 1; avm_readdata = 32'hDEAD_BEEF; end
            if (prev_stalled && (!avm_read || avm_address != prev_addr)) stable_err++;
            if (avm_read && !in_req) begin in_req = 1; stall_rem = sl_stall[avm_address]; end
            if (avm_read && stall_rem > 0) begin
                avm_waitrequest = 1; stall_rem--; stall_seen++;
                prev_stalled = 1; prev_addr = avm_address;
            end else begin
                avm_waitrequest = 0; prev_stalled = 0;
                if (avm_read) begin
                    in_req = 0;
                    iss_addr.push_back(int'(avm_address));
                    if (!sl_nordv) begin
                        rdv_cd = sl_lat[avm_address]; rdv_data = sl_word[avm_address];
                    end
                end
            end
        end
    end

    // Reference result: {done, pass, id_mismatch, ts_mismatch} for a completed check.
    function automatic logic [3:0] model_flags(input logic [31:0] w0, input logic [31:0] w1);
        logic idm, tsm;
        idm = (w0 != EXP_ID);
        tsm = (w1 != EXP_TS);
        return {1'b1, !(idm || tsm), idm, tsm};
    endfunction

    task automatic set_slave(input logic [31:0] w0, input logic [31:0] w1,
                             input int s0, input int s1, input int l0, input int l1);
        sl_word[0] = w0; sl_word[1] = w1;
        sl_stall[0] = s0; sl_stall[1] = s1;
        sl_lat[0] = l0; sl_lat[1] = l1;
    endtask

    // Pulse start; n = number of rising edges (the start-sampling edge is 1) until done.
    task automatic run_check(input int limit, output int n);
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        n = 1;
        while (!done && n < limit) begin @(negedge clock); n++; end
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({busy, done, pass, id_mismatch, ts_mismatch, timeout, avm_read, avm_address, read_id, read_ts} !== '0) begin
            bad++; $display("FAIL reset_outputs got busy=%b done=%b read=%b id=%h ts=%h want all 0", busy, done, avm_read, read_id, read_ts);
        end
        repeat (2) @(negedge clock);
        reset_n = 1;
        repeat (3) @(negedge clock);
        total++;
        if ({busy, done, avm_read} !== 3'b000) begin
            bad++; $display("FAIL idle_after_reset got busy=%b done=%b read=%b want 000", busy, done, avm_read);
        end
    endtask

    task automatic test_basic;
        int n, base;
        set_slave(EXP_ID, EXP_TS, 0, 0, 1, 1);
        base = iss_addr.size();
        run_check(50, n);
        total++;
        if (n !== 5 || done !== 1'b1) begin bad++; $display("FAIL basic_latency got %0d (done=%b) want 5", n, done); end
        total++;
        if ({done, pass, id_mismatch, ts_mismatch} !== model_flags(EXP_ID, EXP_TS)) begin
            bad++; $display("FAIL basic_flags got %b want %b", {done, pass, id_mismatch, ts_mismatch}, model_flags(EXP_ID, EXP_TS));
        end
        total++;
        if (read_ts !== 32'h6606_C6D8 || read_id !== EXP_ID) begin
            bad++; $display("FAIL basic_words got %h/%h want %h/%h", read_id, read_ts, EXP_ID, 32'h6606_C6D8);
        end
        total++;
        if (busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL basic_busy got busy=%b to=%b want 0 0", busy, timeout); end
        total++;
        if (iss_addr.size() - base != 2 || iss_addr[base] != 0 || iss_addr[base+1] != 1) begin
            bad++; $display("FAIL basic_issues got %0d reads want 2 (addr 0 then 1)", iss_addr.size() - base);
        end
    endtask

    task automatic test_id_mismatch;
        int n, base;
        set_slave(32'h1, EXP_TS, 0, 0, 1, 1);
        base = iss_addr.size();
        run_check(50, n);
        total++;
        if ({done, pass, id_mismatch, ts_mismatch} !== model_flags(32'h1, EXP_TS)) begin
            bad++; $display("FAIL idmm_flags got %b want %b", {done, pass, id_mismatch, ts_mismatch}, model_flags(32'h1, EXP_TS));
        end
        total++;
        if (read_id !== 32'h1 || read_ts !== EXP_TS || iss_addr.size() - base != 2) begin
            bad++; $display("FAIL idmm_words got %h/%h reads=%0d want 1/%h reads=2", read_id, read_ts, iss_addr.size() - base, EXP_TS);
        end
    endtask

    task automatic test_stall;
        int n, base, st0, se0;
        set_slave(EXP_ID, EXP_TS, 0, 7, 1, 1);
        base = iss_addr.size(); st0 = stall_seen; se0 = stable_err;
        run_check(80, n);
        total++;
        if (stall_seen - st0 != 7 || stable_err - se0 != 0) begin
            bad++; $display("FAIL stall_stable got stalls=%0d unstable=%0d want 7 0", stall_seen - st0, stable_err - se0);
        end
        total++;
        if (iss_addr.size() - base != 2 || iss_addr[base] != 0 || iss_addr[base+1] != 1) begin
            bad++; $display("FAIL stall_issues got %0d reads want 2", iss_addr.size() - base);
        end
        total++;
        if (pass !== 1'b1 || n !== 12) begin bad++; $display("FAIL stall_result got pass=%b n=%0d want 1 12", pass, n); end
        set_slave(EXP_ID, EXP_TS, 0, 0, 1, 1);
    endtask

    task automatic test_back_to_back;
        int n, base;
        // a start while busy must not restart the sequence
        set_slave(32'h5, EXP_TS, 0, 0, 1, 1);
        base = iss_addr.size();
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        n = 1;
        while (!done && n < 50) begin
            start = (n == 2);
            @(negedge clock); n++;
        end
        start = 0;
        total++;
        if (n !== 5 || iss_addr.size() - base != 2 || id_mismatch !== 1'b1) begin
            bad++; $display("FAIL busy_start got n=%0d reads=%0d idmm=%b want 5 2 1", n, iss_addr.size() - base, id_mismatch);
        end
        // start in DONE clears everything on the next edge and reruns
        set_slave(EXP_ID, EXP_TS, 0, 0, 1, 1);
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        total++;
        if ({done, pass, id_mismatch, ts_mismatch, read_id, read_ts, busy} !== {68'h0, 1'b1}) begin
            bad++; $display("FAIL restart_clear got done=%b idmm=%b id=%h ts=%h busy=%b want 0 0 0 0 1", done, id_mismatch, read_id, read_ts, busy);
        end
        n = 1;
        while (!done && n < 50) begin @(negedge clock); n++; end
        total++;
        if ({done, pass, id_mismatch, ts_mismatch} !== model_flags(EXP_ID, EXP_TS) || n !== 5) begin
            bad++; $display("FAIL restart_result got %b n=%0d want %b 5", {done, pass, id_mismatch, ts_mismatch}, n, model_flags(EXP_ID, EXP_TS));
        end
    endtask

    task automatic test_reset_mid;
        int k, base;
        // reset while a read is being held against waitrequest
        set_slave(EXP_ID, EXP_TS, 0, 20, 1, 1);
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        k = 0;
        while (!(avm_read && avm_address && avm_waitrequest) && k < 50) begin @(negedge clock); k++; end
        #2 reset_n = 0;
        #1;
        total++;
        if (avm_read !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_async_read got read=%b busy=%b want 0 0", avm_read, busy); end
        @(negedge clock) reset_n = 1;
        // reset during WAIT_TS, then a stray readdatavalid
        set_slave(32'h1, EXP_TS, 0, 0, 1, 40);
        base = iss_addr.size();
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
        k = 0;
        while (iss_addr.size() - base < 2 && k < 50) begin @(negedge clock); k++; end
        @(negedge clock);
        total++;
        if (busy !== 1'b1 || id_mismatch !== 1'b1 || read_id !== 32'h1) begin
            bad++; $display("FAIL wait_ts_state got busy=%b idmm=%b id=%h want 1 1 1", busy, id_mismatch, read_id);
        end
        #2 reset_n = 0;
        #1;
        total++;
        if ({busy, done, pass, id_mismatch, ts_mismatch, timeout, avm_read, avm_address, read_id, read_ts} !== '0) begin
            bad++; $display("FAIL reset_wait_ts got busy=%b idmm=%b id=%h want all 0", busy, id_mismatch, read_id);
        end
        @(negedge clock); @(negedge clock) reset_n = 1;
        @(posedge clock); #1 stray_req = 1;
        @(posedge clock); #1 stray_req = 0;
        repeat (4) @(negedge clock);
        total++;
        if ({busy, done, pass, id_mismatch, ts_mismatch, timeout, avm_read, read_id, read_ts} !== '0) begin
            bad++; $display("FAIL stray_rdv got busy=%b done=%b id=%h ts=%h want all 0", busy, done, read_id, read_ts);
        end
        set_slave(EXP_ID, EXP_TS, 0, 0, 1, 1);
    endtask

    task automatic test_random;
        logic [31:0] w0, w1;
        int s0, s1, l0, l1, n, base, want_n;
        for (int it = 0; it < 10; it++) begin
            w0 = $urandom_range(0, 1) ? EXP_ID : $urandom;
            w1 = $urandom_range(0, 1) ? EXP_TS : $urandom;
            s0 = $urandom_range(0, 3); s1 = $urandom_range(0, 3);
            l0 = $urandom_range(1, 3); l1 = $urandom_range(1, 3);
            set_slave(w0, w1, s0, s1, l0, l1);
            want_n = 5 + s0 + s1 + (l0 - 1) + (l1 - 1);
            base = iss_addr.size();
            run_check(100, n);
            total++;
            if ({done, pass, id_mismatch, ts_mismatch} !== model_flags(w0, w1) || read_id !== w0 || read_ts !== w1) begin
                bad++; $display("FAIL rand%0d_result got %b %h/%h want %b %h/%h", it, {done, pass, id_mismatch, ts_mismatch}, read_id, read_ts, model_flags(w0, w1), w0, w1);
            end
            total++;
            if (n !== want_n || iss_addr.size() - base != 2) begin
                bad++; $display("FAIL rand%0d_timing got n=%0d reads=%0d want %0d 2", it, n, iss_addr.size() - base, want_n);
            end
        end
        set_slave(EXP_ID, EXP_TS, 0, 0, 1, 1);
    endtask

    task automatic test_timeout;
        int n, base;
        sl_nordv = 1;
        base = iss_addr.size();
`ifdef SYSID_CHECKER_TIMEOUT_EN
        run_check(500, n);
        total++;
        if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_flags got done=%b to=%b pass=%b busy=%b want 1 1 0 0", done, timeout, pass, busy);
        end
        total++;
        if (iss_addr.size() - base != 3 || iss_addr[base] != 0 || iss_addr[base+1] != 0 || iss_addr[base+2] != 0) begin
            bad++; $display("FAIL timeout_issues got %0d reads want 3 of address 0", iss_addr.size() - base);
        end
        sl_nordv = 0;
`else
        run_check(300, n);
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0 || iss_addr.size() - base != 1) begin
            bad++; $display("FAIL hang_state got done=%b busy=%b to=%b reads=%0d want 0 1 0 1", done, busy, timeout, iss_addr.size() - base);
        end
        sl_nordv = 0;
        @(negedge clock) reset_n = 0;
        @(negedge clock) reset_n = 1;
        @(negedge clock);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL hang_recover got busy=%b want 0", busy); end
`endif
    endtask

    initial begin
        set_slave(EXP_ID, EXP_TS, 0, 0, 1, 1);
        test_reset();
        test_basic();
        test_id_mismatch();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
